sevenseg_scan_driver: RTL

SEVENSEG_SCAN_DRIVER -- requirements
Module: sevenseg_scan_driver

---
 rtl/sevenseg_pkg.sv | 33 +++
 rtl/sevenseg_glyph_rom.sv | 36 +++
 rtl/sevenseg_scan_driver.sv | 96 +++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions and
// active-high glyph encodings (bit0 = a .. bit6 = g).
package sevenseg_pkg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // Segment g alone; shown for 10..15 in decimal mode.
  localparam logic [6:0] GLYPH_DASH = 7'(1 << SEG_G);

endpackage

// File: rtl/sevenseg_glyph_rom.sv
// Combinational nibble-to-glyph lookup; output is always active-high, polarity
// and blanking are the caller's concern.
module sevenseg_glyph_rom
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       mode_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GLYPH_0;
    case (nibble_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      default: seg_o = GLYPH_F;
    endcase
    if (mode_i && (nibble_i > 4'd9)) begin
      seg_o = GLYPH_DASH;
    end
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment driver: digit register file, prescaled scan index and
// registered segment/strobe outputs with leading-zero blanking and polarity control.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned PRESCALE       = 1024,
  parameter bit          ACTIVE_LOW_SEG = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          load,
  input  logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  input  logic [3:0]                    nibble,
  input  logic                          mode,
  input  logic                          blank_lz,
  input  logic                          enable,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         digit_en
);

  localparam int unsigned SelW = $clog2(NUM_DIGITS);
  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam logic [SelW-1:0] LastDigit = SelW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0] LastCount = CntW'(PRESCALE - 1);
  localparam logic [6:0]      SegOff    = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;

  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [SelW-1:0]                 scan_q, scan_d;
  logic [NUM_DIGITS-1:0][3:0]      digits_q;
  logic [6:0]                      seg_q, seg_d;
  logic [NUM_DIGITS-1:0]           en_q, en_d;
  logic                            tick;
  logic                            lead_nz;
  logic                            blank;
  logic [6:0]                      glyph;

  sevenseg_glyph_rom u_rom (
    .nibble_i (digits_q[scan_q]),
    .mode_i   (mode),
    .seg_o    (glyph)
  );

  always_comb begin
    tick   = (cnt_q == LastCount);
    cnt_d  = tick ? '0 : cnt_q + CntW'(1);
    scan_d = scan_q;
    if (tick) begin
      scan_d = (scan_q == LastDigit) ? '0 : scan_q + SelW'(1);
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    lead_nz = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((SelW'(i) >= scan_q) && (digits_q[i] != 4'h0)) begin
        lead_nz = 1'b1;
      end
    end
    blank = blank_lz && (scan_q != '0) && !lead_nz;
  end

  always_comb begin
    seg_d = SegOff;
    en_d  = '0;
    if (enable && !blank) begin
      seg_d = ACTIVE_LOW_SEG ? ~glyph : glyph;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        en_d[i] = (scan_q == SelW'(i));
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      scan_q   <= '0;
      digits_q <= '0;
      seg_q    <= SegOff;
      en_q     <= '0;
    end else begin
      cnt_q  <= cnt_d;
      scan_q <= scan_d;
      if (load && (digit_sel <= LastDigit)) begin
        digits_q[digit_sel] <= nibble;
      end
      seg_q <= seg_d;
      en_q  <= en_d;
    end
  end

  assign seg      = seg_q;
  assign digit_en = en_q;

endmodule
